// File: rtl/pipe_stage_reg_if.sv
// Bundle of the pipe_stage_reg beat, stall/flush controls and perf counters.
// master drives the beat into the stage chain, slave is the register chain itself.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 2,
  parameter int RD_W   = 5
);
  logic              stall_i;
  logic              flush_i;
  logic              valid_i;
  logic [CTRL_W-1:0] ctrl_i;
  logic [DATA_W-1:0] data0_i;
  logic [DATA_W-1:0] data1_i;
  logic [RD_W-1:0]   rd_i;
  logic              valid_o;
  logic [CTRL_W-1:0] ctrl_o;
  logic [DATA_W-1:0] data0_o;
  logic [DATA_W-1:0] data1_o;
  logic [RD_W-1:0]   rd_o;
  logic [15:0]       stall_cnt_o;
  logic [15:0]       bubble_cnt_o;

  modport master (
    output stall_i, flush_i, valid_i, ctrl_i, data0_i, data1_i, rd_i,
    input  valid_o, ctrl_o, data0_o, data1_o, rd_o, stall_cnt_o, bubble_cnt_o
  );

  modport slave (
    input  stall_i, flush_i, valid_i, ctrl_i, data0_i, data1_i, rd_i,
    output valid_o, ctrl_o, data0_o, data1_o, rd_o, stall_cnt_o, bubble_cnt_o
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// DEPTH-deep pipeline register with per-stage valid, stall hold and flush bubbles.
// Define PIPE_STAGE_REG_PERF_CNT_EN to build the saturating stall/bubble counters.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 2,
  parameter int RD_W   = 5,
  parameter int DEPTH  = 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  pipe_stage_reg_if.slave bus
);

  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("pipe_stage_reg: DEPTH must be in 1..4");
  end

  logic              r_valid [DEPTH];
  logic [CTRL_W-1:0] r_ctrl  [DEPTH];
  logic [DATA_W-1:0] r_data0 [DEPTH];
  logic [DATA_W-1:0] r_data1 [DEPTH];
  logic [RD_W-1:0]   r_rd    [DEPTH];

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_valid[k] <= 1'b0;
        r_ctrl[k]  <= '0;
        r_data0[k] <= '0;
        r_data1[k] <= '0;
        r_rd[k]    <= '0;
      end
    end else if (bus.flush_i) begin
      // data/rd are left alone; only the qualifying fields are dropped
      for (int k = 0; k < DEPTH; k++) begin
        r_valid[k] <= 1'b0;
        r_ctrl[k]  <= '0;
      end
    end else if (!bus.stall_i) begin
      r_valid[0] <= bus.valid_i;
      r_ctrl[0]  <= bus.ctrl_i & {CTRL_W{bus.valid_i}};
      r_data0[0] <= bus.data0_i;
      r_data1[0] <= bus.data1_i;
      r_rd[0]    <= bus.rd_i;
      for (int k = 1; k < DEPTH; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_ctrl[k]  <= r_ctrl[k-1];
        r_data0[k] <= r_data0[k-1];
        r_data1[k] <= r_data1[k-1];
        r_rd[k]    <= r_rd[k-1];
      end
    end
  end

  assign bus.valid_o = r_valid[DEPTH-1];
  assign bus.ctrl_o  = r_ctrl[DEPTH-1];
  assign bus.data0_o = r_data0[DEPTH-1];
  assign bus.data1_o = r_data1[DEPTH-1];
  assign bus.rd_o    = r_rd[DEPTH-1];

`ifdef PIPE_STAGE_REG_PERF_CNT_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_bubble_cnt;
  logic        w_stall_inc;
  logic        w_bubble_inc;

  assign w_stall_inc  = bus.stall_i & ~bus.flush_i;
  assign w_bubble_inc = bus.flush_i | (~bus.stall_i & ~bus.valid_i);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_stall_inc && r_stall_cnt != 16'hFFFF)
        r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_bubble_inc && r_bubble_cnt != 16'hFFFF)
        r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end
  end

  assign bus.stall_cnt_o  = r_stall_cnt;
  assign bus.bubble_cnt_o = r_bubble_cnt;
`else
  assign bus.stall_cnt_o  = 16'h0000;
  assign bus.bubble_cnt_o = 16'h0000;
`endif

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register for the five-stage CPU, used in place of the single-purpose inter-stage latches. It carries a write-back control field, two data words and a destination register index through DEPTH register stages. Each stage has its own valid bit, and the whole chain supports stall (hold) and flush (bubble insertion). Optional saturating counters record stall and bubble cycles for performance analysis.

## Interface
- DATA_W, 32: width of each data word.
- CTRL_W, 2: width of the control field (bit 0 MemtoReg, bit 1 RegWrite in the MEM/WB instance).
- RD_W, 5: destination register index width.
- DEPTH, 1: number of register stages, legal range 1..4.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- stall_i  in  1  hold every stage.
- flush_i  in  1  invalidate every stage.
- valid_i  in  1  input beat carries a real instruction.
- ctrl_i  in  CTRL_W  control field.
- data0_i  in  DATA_W  first data word (ALU result).
- data1_i  in  DATA_W  second data word (memory read data).
- rd_i  in  RD_W  destination register.
- valid_o  out  1  last stage holds a real instruction.
- ctrl_o  out  CTRL_W  last-stage control; all-zero whenever valid_o=0.
- data0_o  out  DATA_W  last-stage data0.
- data1_o  out  DATA_W  last-stage data1.
- rd_o  out  RD_W  last-stage destination.
- stall_cnt_o  out  16  stall-cycle counter.
- bubble_cnt_o  out  16  bubble-cycle counter.

## Operation
- Per-stage state: valid, ctrl, data0, data1, rd. Stage 0 captures the inputs; stage DEPTH-1 drives the outputs.
- Per-cycle priority is reset > flush > stall > advance.
- **Reset** (rst_i=0 at the edge): every stage's valid, ctrl, data and rd is cleared to 0. Counters are cleared to 0.
- **Flush** (flush_i=1): every stage's valid and ctrl are cleared. Data and rd keep their values. Flush wins over a simultaneous stall.
- **Stall** (stall_i=1, flush_i=0): every stage holds its value, including stage 0. Inputs are ignored.
- **Advance** (stall_i=0, flush_i=0):
  - stage k takes stage k-1's value;
  - stage 0 takes the inputs;
  - ctrl is stored as ctrl_i & {CTRL_W{valid_i}}, so an invalid beat enters as a bubble with zero control;
  - data and rd are captured regardless of valid_i.
- Invariant: no stage ever holds valid=0 with nonzero ctrl.
- Counters, when compiled in, saturate at 16'hFFFF and never wrap:
  - stall_cnt increments on each cycle with stall_i=1 and flush_i=0;
  - bubble_cnt increments on each advance cycle with valid_i=0, and on each flush cycle.
- An illegal DEPTH (outside 1..4) is an elaboration-time error.

## Timing
- Latency: an input accepted at edge n appears on the outputs after edge n+DEPTH-1. For DEPTH=1, the outputs change one edge after acceptance.
- Each stall cycle adds exactly one cycle of latency to every in-flight beat.
- Outputs are purely registered, with no combinational path from any input to any output.
- Flush takes effect at the edge where it is sampled. valid_o is 0 in the following cycle.
- Reset mid-stall or mid-flush: reset wins, and all state is zero on the next cycle.
- Deassertion of reset: the first edge with rst_i=1 is a normal cycle.

## Configuration
- Macro PIPE_STAGE_REG_PERF_CNT_EN.
- Defined: both counters are implemented as described.
- Undefined: counter logic is omitted; stall_cnt_o and bubble_cnt_o are tied to 16'h0000, and the port list is unchanged.

## Test plan
- Reset then idle, DEPTH=1: with rst_i=0 for 2 cycles, all outputs read 0. With the PERF_CNT_EN build, after 3 idle cycles with valid_i=0, bubble_cnt_o=3.
- Pass-through, DEPTH=3: driving valid_i=1, ctrl_i=2'b11, data0_i=32'h1234_5678, data1_i=32'hDEAD_BEEF, rd_i=5'd7 for one cycle makes valid_o=1 with the same values exactly 3 edges later, for one cycle only.
- Stall hold, DEPTH=1: beat A=32'hA is captured, then stall_i=1 for 4 cycles while data0_i changes. Outputs hold A, and stall_cnt_o=4.
- Flush vs stall, DEPTH=2: with two valid beats in flight, assert stall_i=1 and flush_i=1 together. Next cycle valid_o=0 and ctrl_o=0; the next advance yields only new input.
- Bubble gating: valid_i=0 with ctrl_i=2'b11 gives valid_o=0 and ctrl_o=2'b00 at the output. data0_o still equals the captured data0_i.
- Saturation: force 70000 stall cycles. stall_cnt_o stays at 16'hFFFF, with no wrap to 0.
